// File: rtl/cl_frame_buf_if.sv
// Line-in / frame-out handshake bundle for cl_frame_buf.
// slave = buffer side, master = producer/consumer side.
interface cl_frame_buf_if #(
  parameter int CL         = 512,
  parameter int W_LEN      = 16,
  parameter int MAX_FRAMES = 4
);
  localparam int FCW = $clog2(MAX_FRAMES) + 1;

  logic [CL-1:0]    sink_data;
  logic             sink_valid;
  logic             sink_ready;
  logic             ff_rd_ready;
  logic             ff_rdreq;
  logic [CL-1:0]    ff_q;
  logic             ff_q_valid;
  logic [W_LEN-1:0] sb_len;
  logic [FCW-1:0]   frame_cnt;
  logic             err_orphan;
  logic             err_abort;
  logic             err_oversize;

  modport slave (
    input  sink_data, sink_valid, ff_rdreq,
    output sink_ready, ff_rd_ready, ff_q, ff_q_valid, sb_len, frame_cnt,
           err_orphan, err_abort, err_oversize
  );

  modport master (
    output sink_data, sink_valid, ff_rdreq,
    input  sink_ready, ff_rd_ready, ff_q, ff_q_valid, sb_len, frame_cnt,
           err_orphan, err_abort, err_oversize
  );
endinterface

// File: rtl/cl_frame_buf.sv
// Cache-line frame buffer: assembles SOF..EOF frames, exposes only committed
// frames to the reader, with a length queue giving each frame's size.
//
// state   | meaning
// IDLE    | between frames; SOF starts a frame, anything else is an orphan
// FRAME   | collecting lines of an uncommitted frame
// DISCARD | after an oversize frame; drop lines until the next SOF
module cl_frame_buf #(
  parameter int CL         = 512,
  parameter int CL_HEAD    = 16,
  parameter int DEPTH      = 256,
  parameter int MAX_FRAMES = 4,
  parameter int MAX_LEN    = 256,
  parameter int W_LEN      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cl_frame_buf_if.slave  bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int FAW     = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int FCW     = $clog2(MAX_FRAMES) + 1;
  localparam int LW      = $clog2(MAX_LEN + 2);
  localparam int HDR_LSB = CL - CL_HEAD;
  localparam int SOF_BIT = HDR_LSB + CL_HEAD - 1;
  localparam int EOF_BIT = HDR_LSB + CL_HEAD - 2;
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

  state_t           state;
  logic [CL-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    cm_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    len_cnt;
  logic [W_LEN-1:0] lq [1<<FAW];
  logic [FAW-1:0]   lq_wr;
  logic [FAW-1:0]   lq_rd;
  logic [FCW-1:0]   frame_cnt;
  logic [W_LEN-1:0] rd_cnt;
  logic             rdy_en;
  logic [CL-1:0]    ff_q;
  logic             ff_q_valid;
  logic             err_orphan;
  logic             err_abort;
  logic             err_oversize;

  logic [PW-1:0]    used;
  logic             full;
  logic             sink_ready;
  logic             accept;
  logic             sof;
  logic             eof;
  logic [LW-1:0]    len_inc;
  logic             start;
  logic             cont;
  logic             over;
  logic             orphan;
  logic             abort;
  logic [PW-1:0]    wr_base;
  logic             wr_en;
  logic             commit;
  logic [LW-1:0]    commit_len;
  logic             rd_ready;
  logic [W_LEN-1:0] head_len;
  logic             rd_fire;
  logic             pop;

  // Uncommitted lines occupy space too, so fullness is measured from rd_ptr.
  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == PW'(DEPTH));
  assign sink_ready = rdy_en && !full && (frame_cnt < FCW'(MAX_FRAMES));
  assign accept     = bus.sink_valid && sink_ready;
  assign sof        = bus.sink_data[SOF_BIT];
  assign eof        = bus.sink_data[EOF_BIT];

  assign len_inc    = (len_cnt == LEN_SAT) ? len_cnt : len_cnt + 1'b1;
  assign start      = accept && sof;
  assign cont       = accept && !sof && (state == FRAME) && (len_inc != LEN_SAT);
  assign over       = accept && !sof && (state == FRAME) && (len_inc == LEN_SAT);
  assign orphan     = accept && !sof && (state == IDLE);
  assign abort      = start && (state == FRAME);
  // A SOF always restarts at the commit point, discarding any partial frame.
  assign wr_base    = start ? cm_ptr : wr_ptr;
  assign wr_en      = start || cont;
  assign commit     = wr_en && eof;
  assign commit_len = start ? LW'(1) : len_inc;

  assign rd_ready   = (frame_cnt != '0);
  assign head_len   = lq[lq_rd];
  assign rd_fire    = bus.ff_rdreq && rd_ready;
  assign pop        = rd_fire && ((rd_cnt + 1'b1) == head_len);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_base[AW-1:0]] <= bus.sink_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      cm_ptr       <= '0;
      rd_ptr       <= '0;
      len_cnt      <= '0;
      lq_wr        <= '0;
      lq_rd        <= '0;
      frame_cnt    <= '0;
      rd_cnt       <= '0;
      rdy_en       <= 1'b0;
      ff_q         <= '0;
      ff_q_valid   <= 1'b0;
      err_orphan   <= 1'b0;
      err_abort    <= 1'b0;
      err_oversize <= 1'b0;
      for (int i = 0; i < (1 << FAW); i++) lq[i] <= '0;
    end else begin
      rdy_en       <= 1'b1;
      err_orphan   <= orphan;
      err_abort    <= abort;
      err_oversize <= over;

      if (wr_en)     wr_ptr <= wr_base + 1'b1;
      else if (over) wr_ptr <= cm_ptr;

      if (start)     len_cnt <= LW'(1);
      else if (cont) len_cnt <= len_inc;

      if (commit) begin
        cm_ptr    <= wr_base + 1'b1;
        lq[lq_wr] <= W_LEN'(commit_len);
        lq_wr     <= lq_wr + 1'b1;
      end

      if (start)              state <= eof ? IDLE : FRAME;
      else if (cont && eof)   state <= IDLE;
      else if (over)          state <= DISCARD;

      if (rd_fire) begin
        ff_q       <= mem[rd_ptr[AW-1:0]];
        ff_q_valid <= 1'b1;
        rd_ptr     <= rd_ptr + 1'b1;
        rd_cnt     <= pop ? '0 : rd_cnt + 1'b1;
        if (pop) lq_rd <= lq_rd + 1'b1;
      end else begin
        ff_q_valid <= 1'b0;
      end

      case ({commit, pop})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  assign bus.sink_ready   = sink_ready;
  assign bus.ff_rd_ready  = rd_ready;
  assign bus.sb_len       = rd_ready ? head_len : '0;
  assign bus.frame_cnt    = frame_cnt;
  assign bus.ff_q         = ff_q;
  assign bus.ff_q_valid   = ff_q_valid;
  assign bus.err_orphan   = err_orphan;
  assign bus.err_abort    = err_abort;
  assign bus.err_oversize = err_oversize;
endmodule
